// File: rtl/demosaic_frame_ctrl.sv
// Frame sequencer in front of the demosaicing core: gates frames on enable at
// frame boundaries, regenerates tuser/tlast, flags malformed input, zero-pads.
module demosaic_frame_ctrl #(
  parameter int unsigned Nrows = 349,
  parameter int unsigned Ncol  = 349,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic [7:0]       s_axis_tdata,
  output logic             s_axis_tready,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic [7:0]       m_axis_tdata,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic             frame_done,
  output logic             err_sof,
  output logic             err_eol,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int unsigned ROW_W = (Nrows > 1) ? $clog2(Nrows) : 1;
  localparam int unsigned COL_W = (Ncol > 1) ? $clog2(Ncol) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(Nrows - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(Ncol - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, PAD} state_t;

  state_t           state, state_d;
  logic [ROW_W-1:0] row, row_d;
  logic [COL_W-1:0] col, col_d;
  logic             at_sof, at_eol, at_end;
  logic             premature, hs, in_frame, frame_end, eol_bad;

  // Stream outputs, counter advance and next state
  always_comb begin
    state_d       = state;
    row_d         = row;
    col_d         = col;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = 8'h00;
    premature     = 1'b0;
    at_sof        = (row == ROW_W'(0)) && (col == COL_W'(0));
    at_eol        = (col == COL_LAST);
    at_end        = at_eol && (row == ROW_LAST);

    case (state)
      WAIT_SOF: s_axis_tready = ~s_axis_tuser;
      ACTIVE: begin
        // A new SOF mid-frame is held upstream and never forwarded
        premature     = s_axis_tvalid && s_axis_tuser && !at_sof;
        m_axis_tvalid = s_axis_tvalid && !premature;
        s_axis_tready = m_axis_tready && !premature;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tuser  = at_sof;
        m_axis_tlast  = at_eol;
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tuser  = at_sof;
        m_axis_tlast  = at_eol;
      end
      default: ;
    endcase

    hs        = m_axis_tvalid && m_axis_tready;
    in_frame  = (state == ACTIVE) || (state == PAD);
    frame_end = hs && at_end && in_frame;
    eol_bad   = (state == ACTIVE) && hs && (s_axis_tlast != at_eol);

    if (hs) begin
      if (at_eol) begin
        col_d = COL_W'(0);
        row_d = at_end ? ROW_W'(0) : row + ROW_W'(1);
      end else begin
        col_d = col + COL_W'(1);
      end
    end

    case (state)
      IDLE: if (enable) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (s_axis_tvalid && s_axis_tuser) begin
          state_d = ACTIVE;
          row_d   = ROW_W'(0);
          col_d   = COL_W'(0);
        end
      end
      ACTIVE: begin
        if (premature)      state_d = PAD;
        else if (frame_end) state_d = enable ? WAIT_SOF : IDLE;
      end
      PAD: if (frame_end) state_d = enable ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= ROW_W'(0);
      col        <= COL_W'(0);
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
      err_eol    <= 1'b0;
      frame_cnt  <= CNT_W'(0);
    end else begin
      state      <= state_d;
      row        <= row_d;
      col        <= col_d;
      busy       <= (state_d == ACTIVE) || (state_d == PAD);
      frame_done <= frame_end;
      err_sof    <= premature;
      err_eol    <= eol_bad;
      if (frame_end) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// Self-checking bench for demosaic_frame_ctrl: linear-pixel reference model,
// directed frame scenarios and a randomized stress phase.
module tb_demosaic_frame_ctrl;
  localparam int unsigned NR   = 4;
  localparam int unsigned NC   = 4;
  localparam int unsigned CW   = 16;
  localparam int          NPIX = NR * NC;
  localparam int M_OFF = 0, M_HUNT = 1, M_PASS = 2, M_FILL = 3;

  typedef struct packed {
    logic       u;
    logic       l;
    logic [7:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic [7:0]    s_tdata = 8'h00;
  logic          s_tready;
  logic          m_tvalid, m_tuser, m_tlast;
  logic [7:0]    m_tdata;
  logic          m_tready = 1'b0;
  logic          busy, frame_done, err_sof, err_eol;
  logic [CW-1:0] frame_cnt;

  demosaic_frame_ctrl #(.Nrows(NR), .Ncol(NC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tdata(s_tdata), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tready(m_tready),
    .busy(busy), .frame_done(frame_done), .err_sof(err_sof), .err_eol(err_eol),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream source: queue of beats, valid held until accepted
  beat_t srcq[$];
  int    valid_pct = 100;
  int    ready_pct = 100;
  bit    rdy_toggle = 1'b0;
  int    cyc = 0;
  logic  held = 1'b0;
  logic  taken;

  task automatic push_frame(input int len, input int bad_at, input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.u = (i == 0);
      b.l = ((i % NC) == NC - 1);
      if (i == bad_at) b.l = ~b.l;
      b.d = base + 8'(i);
      srcq.push_back(b);
    end
  endtask

  task automatic push_junk(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.u = 1'b0;
      b.l = 1'($urandom_range(1));
      b.d = 8'($urandom_range(255));
      srcq.push_back(b);
    end
  endtask

  task automatic drive_inputs();
    logic [3:0] pat;
    pat = 4'b1001;
    if (srcq.size() > 0 && (held || $urandom_range(99) < valid_pct)) begin
      s_tvalid = 1'b1;
      {s_tuser, s_tlast, s_tdata} = srcq[0];
    end else begin
      s_tvalid = 1'b0;
      s_tuser  = 1'($urandom_range(1));
      s_tlast  = 1'($urandom_range(1));
      s_tdata  = 8'($urandom_range(255));
    end
    if (rdy_toggle) m_tready = pat[3 - (cyc % 4)];
    else            m_tready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic tick();
    drive_inputs();
    @(negedge clk);
    taken = s_tvalid & s_tready;
    held  = s_tvalid & ~s_tready;
    @(posedge clk);
    #1;
    cyc++;
    if (taken && srcq.size() > 0) void'(srcq.pop_front());
  endtask

  // Reference model: frame position as a linear pixel index
  int            m_mode = M_OFF;
  int            m_pix = 0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_done = 1'b0, m_esof = 1'b0, m_eeol = 1'b0, m_busy = 1'b0;
  logic          e_srdy, e_mval, e_muser, e_mlast, prem, mhs, m_last;
  logic [7:0]    e_mdata;

  // Output-frame recorder
  int          fb = 0, cur_zero = 0, out_beats_total = 0, done_total = 0;
  int          n_esof = 0, n_eeol = 0;
  logic [31:0] cur_tl = '0, cur_tu = '0;
  logic [7:0]  cur_first = '0;
  int          f_beats = 0, f_zero = 0;
  logic [31:0] f_tl = '0, f_tu = '0;
  logic [7:0]  f_first = '0;

  always @(negedge clk) begin : compare
    e_srdy = 1'b0; e_mval = 1'b0; e_muser = 1'b0; e_mlast = 1'b0; e_mdata = 8'h00; prem = 1'b0;
    case (m_mode)
      M_HUNT: e_srdy = ~s_tuser;
      M_PASS: begin
        prem    = s_tvalid && s_tuser && (m_pix != 0);
        e_mval  = s_tvalid && !prem;
        e_srdy  = m_tready && !prem;
        e_mdata = s_tdata;
        e_muser = (m_pix == 0);
        e_mlast = ((m_pix % NC) == NC - 1);
      end
      M_FILL: begin
        e_mval  = 1'b1;
        e_muser = (m_pix == 0);
        e_mlast = ((m_pix % NC) == NC - 1);
      end
      default: ;
    endcase

    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("err_sof", 32'(err_sof), 32'(m_esof));
    chk("err_eol", 32'(err_eol), 32'(m_eeol));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("s_tready", 32'(s_tready), 32'(e_srdy));
    chk("m_tvalid", 32'(m_tvalid), 32'(e_mval));
    if (e_mval || m_mode == M_OFF || m_mode == M_HUNT) begin
      chk("m_tdata", 32'(m_tdata), 32'(e_mdata));
      chk("m_tuser", 32'(m_tuser), 32'(e_muser));
      chk("m_tlast", 32'(m_tlast), 32'(e_mlast));
    end

    if (frame_done === 1'b1) begin
      f_beats = fb; f_zero = cur_zero; f_tl = cur_tl; f_tu = cur_tu; f_first = cur_first;
      done_total++;
      fb = 0; cur_zero = 0; cur_tl = '0; cur_tu = '0;
    end
    if (err_sof === 1'b1) n_esof++;
    if (err_eol === 1'b1) n_eeol++;
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      if (fb < 32) begin
        cur_tl[fb] = m_tlast;
        cur_tu[fb] = m_tuser;
      end
      if (fb == 0) cur_first = m_tdata;
      if (m_tdata == 8'h00) cur_zero++;
      fb++;
      out_beats_total++;
    end
    if (rst) begin
      fb = 0; cur_zero = 0; cur_tl = '0; cur_tu = '0;
    end

    mhs = e_mval && m_tready;
    if (rst) begin
      m_mode = M_OFF; m_pix = 0; m_cnt = '0;
      m_done = 1'b0; m_esof = 1'b0; m_eeol = 1'b0;
    end else begin
      m_last = mhs && (m_pix == NPIX - 1) && (m_mode == M_PASS || m_mode == M_FILL);
      m_done = m_last;
      m_esof = prem;
      m_eeol = (m_mode == M_PASS) && mhs && (s_tlast != e_mlast);
      if (m_last) m_cnt = m_cnt + 1'b1;
      if (mhs) m_pix = m_last ? 0 : m_pix + 1;
      case (m_mode)
        M_OFF:  if (enable) m_mode = M_HUNT;
        M_HUNT: begin
          if (!enable) m_mode = M_OFF;
          else if (s_tvalid && s_tuser) begin m_mode = M_PASS; m_pix = 0; end
        end
        M_PASS: begin
          if (prem)        m_mode = M_FILL;
          else if (m_last) m_mode = enable ? M_HUNT : M_OFF;
        end
        M_FILL: if (m_last) m_mode = enable ? M_PASS : M_OFF;
        default: m_mode = M_OFF;
      endcase
    end
    m_busy = (m_mode == M_PASS || m_mode == M_FILL);
  end

  task automatic wait_beats(input int n);
    int tgt, k;
    tgt = out_beats_total + n;
    k = 0;
    while (out_beats_total < tgt && k < 600) begin tick(); k++; end
    chk("wait_beats_timeout", 32'(out_beats_total >= tgt), 32'd1);
  endtask

  task automatic wait_done();
    int tgt, k;
    tgt = done_total + 1;
    k = 0;
    while (done_total < tgt && k < 600) begin tick(); k++; end
    chk("wait_done_timeout", 32'(done_total >= tgt), 32'd1);
  endtask

  int base_eol, base_sof;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);

    // Reset in the middle of a frame abandons it
    enable = 1'b1;
    push_frame(NPIX, -1, 8'h10);
    wait_beats(8);
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0;
    srcq.delete(); held = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(frame_done), 32'd0);
    chk("midrst_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_mval", 32'(m_tvalid), 32'd0);

    // Clean frame
    base_eol = n_eeol; base_sof = n_esof;
    enable = 1'b1;
    push_frame(NPIX, -1, 8'h20);
    wait_done();
    chk("clean_beats", 32'(f_beats), 32'd16);
    chk("clean_tlast", f_tl, 32'h0000_8888);
    chk("clean_tuser", f_tu, 32'h0000_0001);
    chk("clean_cnt", 32'(frame_cnt), 32'd1);
    chk("model_cnt", 32'(m_cnt), 32'd1);
    chk("clean_errs", 32'((n_eeol - base_eol) + (n_esof - base_sof)), 32'd0);

    // Junk before SOF is dropped
    push_junk(3);
    push_frame(NPIX, -1, 8'hA5);
    wait_done();
    chk("junk_first", 32'(f_first), 32'hA5);
    chk("junk_beats", 32'(f_beats), 32'd16);
    chk("junk_cnt", 32'(frame_cnt), 32'd2);

    // Wrong input tlast at row 1 col 2
    base_eol = n_eeol;
    push_frame(NPIX, 6, 8'h50);
    wait_done();
    tick();
    chk("eol_pulses", 32'(n_eeol - base_eol), 32'd1);
    chk("eol_tlast", f_tl, 32'h0000_8888);
    chk("eol_beats", 32'(f_beats), 32'd16);

    // Truncated frame padded with stalls, then held SOF starts next frame
    base_sof = n_esof;
    rdy_toggle = 1'b1;
    push_frame(6, -1, 8'h70);
    push_frame(NPIX, -1, 8'hC3);
    wait_done();
    chk("pad_sof_pulses", 32'(n_esof - base_sof), 32'd1);
    chk("pad_beats", 32'(f_beats), 32'd16);
    chk("pad_zeros", 32'(f_zero), 32'd10);
    chk("pad_tlast", f_tl, 32'h0000_8888);
    wait_done();
    rdy_toggle = 1'b0;
    chk("held_first", 32'(f_first), 32'hC3);
    chk("held_tuser", f_tu, 32'h0000_0001);
    chk("held_cnt", 32'(frame_cnt), 32'd5);

    // Enable dropped mid-frame: frame completes, then idle
    push_frame(NPIX, -1, 8'h30);
    wait_beats(5);
    enable = 1'b0;
    wait_done();
    push_junk(2);
    repeat (2) tick();
    chk("dis_beats", 32'(f_beats), 32'd16);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_s_tready", 32'(s_tready), 32'd0);
    chk("dis_cnt", 32'(frame_cnt), 32'd6);
    srcq.delete(); held = 1'b0;

    // Randomized stress
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        enable    = ($urandom_range(99) < 85);
        valid_pct = $urandom_range(40, 100);
        ready_pct = $urandom_range(40, 100);
      end
      rst = ($urandom_range(999) < 2);
      if (srcq.size() < 40) begin
        int len, bad;
        push_junk($urandom_range(2));
        len = ($urandom_range(99) < 25) ? $urandom_range(1, NPIX - 1) : NPIX;
        bad = ($urandom_range(99) < 25) ? $urandom_range(0, len - 1) : -1;
        push_frame(len, bad, 8'($urandom_range(255)));
      end
      tick();
    end
    rst = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
